// File: rtl/multicycle_mem_pkg.sv
// Shared types and constants for the multicycle core's memory port adapter.
package multicycle_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } mem_port_state_t;

    // Load/store funct3 encodings; stores reuse the low two bits as size.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MC_ADDR_W = 32;

    typedef struct packed {
        logic [MC_ADDR_W-1:0] addr;
        logic [3:0]           be;
        logic [31:0]          data;
    } wb_entry_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_formatter.sv
// Combinational lane logic: store byte-enable/replication and load extract/extend.
module mem_lane_formatter
    import multicycle_mem_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_is_data,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_word[{i_ld_off, 3'b000} +: 8];
    assign w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    always_comb begin
        o_st_be   = 4'hF;
        o_st_data = i_st_wdata;
        case (i_st_funct3)
            F3_B: begin
                o_st_be   = 4'b0001 << i_st_off;
                o_st_data = {4{i_st_wdata[7:0]}};
            end
            F3_H: begin
                o_st_be   = 4'b0011 << {i_st_off[1], 1'b0};
                o_st_data = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_word;
        if (i_ld_is_data) begin
            case (i_ld_funct3)
                F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
                F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
                F3_BU:   o_ld_data = {24'h0, w_byte};
                F3_HU:   o_ld_data = {16'h0, w_half};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_mem_port.sv
// Multicycle core to valid/ready bus adapter: formatted reads, posted one-entry store buffer.
// Build option MC_MEM_MISALIGN_TRAP_EN adds the `misaligned` output and drops misaligned stores.
module multicycle_mem_port
    import multicycle_mem_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [3:0] BUS_ID     = 4'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic                  inst_or_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [2:0]            funct3,
    output logic                  data_available,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_req_write,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic [31:0]           bus_req_wdata,
    output logic [3:0]            bus_req_be,
    output logic [3:0]            bus_req_id,
    input  logic                  bus_resp_valid,
    input  logic [31:0]           bus_resp_data
`ifdef MC_MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misaligned
`endif
);

    mem_port_state_t       r_state, w_next;
    wb_entry_t             r_wb;
    logic                  r_wb_full;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [2:0]            r_rd_funct3;
    logic                  r_rd_iod, r_rd_live;
    logic [31:0]           r_rdata;
    logic [3:0]            w_st_be;
    logic [31:0]           w_st_data, w_ld_data;
    logic                  w_st_trap, w_ld_trap, w_capture, w_drain, w_rd_launch, w_data_available;

    mem_lane_formatter u_fmt (
        .i_st_funct3  (funct3),
        .i_st_off     (addr[1:0]),
        .i_st_wdata   (wdata),
        .o_st_be      (w_st_be),
        .o_st_data    (w_st_data),
        .i_ld_funct3  (r_rd_funct3),
        .i_ld_off     (r_rd_addr[1:0]),
        .i_ld_is_data (r_rd_iod),
        .i_ld_word    (bus_resp_data),
        .o_ld_data    (w_ld_data)
    );

`ifdef MC_MEM_MISALIGN_TRAP_EN
    assign w_st_trap  = mem_write_enable && is_misaligned(funct3, addr[1:0]);
    assign w_ld_trap  = r_rd_iod && is_misaligned(r_rd_funct3, r_rd_addr[1:0]);
    assign misaligned = w_st_trap || (w_data_available && w_ld_trap);
`else
    assign w_st_trap = 1'b0;
    assign w_ld_trap = 1'b0;
`endif

    // A store arriving on the drain cycle replaces the entry being retired.
    assign w_drain     = (r_state == WR_REQ) && bus_req_ready;
    assign w_capture   = mem_write_enable && !w_st_trap && (!r_wb_full || w_drain);
    assign w_rd_launch = (r_state == IDLE) && (w_next == RD_REQ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A store captured this cycle counts as pending so it drains ahead of a simultaneous read.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_wb_full || w_capture) w_next = WR_REQ;
                     else if (mem_read_enable)   w_next = RD_REQ;
            WR_REQ:  if (bus_req_ready)  w_next = IDLE;
            RD_REQ:  if (bus_req_ready)  w_next = RD_WAIT;
            RD_WAIT: if (bus_resp_valid) w_next = RD_DONE;
            RD_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req_valid    = 1'b0;
        bus_req_write    = 1'b0;
        bus_req_addr     = '0;
        bus_req_wdata    = '0;
        bus_req_be       = '0;
        w_data_available = 1'b0;
        case (r_state)
            WR_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_write = 1'b1;
                bus_req_addr  = r_wb.addr[ADDR_WIDTH-1:0];
                bus_req_wdata = r_wb.data;
                bus_req_be    = r_wb.be;
            end
            RD_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_addr  = {r_rd_addr[ADDR_WIDTH-1:2], 2'b00};
                bus_req_be    = 4'hF;
            end
            RD_DONE: w_data_available = r_rd_live && mem_read_enable;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wb_full   <= 1'b0;
            r_wb        <= '0;
            r_rd_addr   <= '0;
            r_rd_funct3 <= '0;
            r_rd_iod    <= 1'b0;
            r_rd_live   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_capture) begin
                r_wb_full <= 1'b1;
                r_wb      <= '{addr: MC_ADDR_W'({addr[ADDR_WIDTH-1:2], 2'b00}),
                               be: w_st_be, data: w_st_data};
            end else if (w_drain) begin
                r_wb_full <= 1'b0;
            end
            // An abandoned read still completes on the bus but never signals the core.
            if (w_rd_launch) begin
                r_rd_addr   <= addr;
                r_rd_funct3 <= funct3;
                r_rd_iod    <= inst_or_data;
                r_rd_live   <= 1'b1;
            end else if (!mem_read_enable && r_state != IDLE && r_state != WR_REQ) begin
                r_rd_live   <= 1'b0;
            end
            if (r_state == RD_WAIT && bus_resp_valid)
                r_rdata <= w_ld_trap ? 32'h0 : w_ld_data;
        end
    end

    always @(posedge clock) begin
        if (!reset) assert (!(mem_write_enable && r_wb_full && !w_drain));
    end

    assign data_available = w_data_available;
    assign rdata          = r_rdata;
    assign busy           = r_wb_full || r_state == RD_REQ || r_state == RD_WAIT;
    assign bus_req_id     = BUS_ID;

endmodule

// File: tb/tb_multicycle_mem_port.sv
// Directed bench for multicycle_mem_port: reads, load formatting, posted stores, ordering, abort, reset.
module tb_multicycle_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read_enable, mem_write_enable, inst_or_data;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic        data_available;
    logic [31:0] rdata;
    logic        busy;
    logic        bus_req_valid, bus_req_ready, bus_req_write;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_be, bus_req_id;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
`ifdef MC_MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multicycle_mem_port #(.ADDR_WIDTH(32), .BUS_ID(4'd0)) dut (
        .clock            (clock),
        .reset            (reset),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .inst_or_data     (inst_or_data),
        .addr             (addr),
        .wdata            (wdata),
        .funct3           (funct3),
        .data_available   (data_available),
        .rdata            (rdata),
        .busy             (busy),
        .bus_req_valid    (bus_req_valid),
        .bus_req_ready    (bus_req_ready),
        .bus_req_write    (bus_req_write),
        .bus_req_addr     (bus_req_addr),
        .bus_req_wdata    (bus_req_wdata),
        .bus_req_be       (bus_req_be),
        .bus_req_id       (bus_req_id),
        .bus_resp_valid   (bus_resp_valid),
        .bus_resp_data    (bus_resp_data)
`ifdef MC_MEM_MISALIGN_TRAP_EN
        ,
        .misaligned       (misaligned)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Bus responds one cycle after the read request is accepted; ready held high.
    task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic iod, input logic [31:0] resp, input logic [31:0] exp_data,
                           input logic exp_mis);
        int          lat, pulses;
        logic        pend, mis;
        logic [31:0] got, req_a;
        lat = 0; pulses = 0; pend = 1'b0; mis = 1'b0; got = 32'h0; req_a = 32'hFFFF_FFFF;
        addr = a; funct3 = f3; inst_or_data = iod; mem_read_enable = 1'b1; bus_req_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            cyc();
            bus_resp_valid = pend;
            bus_resp_data  = resp;
            pend = 1'b0;
            #1;
            if (bus_req_valid && !bus_req_write) begin
                pend  = 1'b1;
                req_a = bus_req_addr;
            end
            if (data_available) begin
                pulses++;
                if (lat == 0) begin
                    lat = n;
                    got = rdata;
`ifdef MC_MEM_MISALIGN_TRAP_EN
                    mis = misaligned;
`endif
                end
                mem_read_enable = 1'b0;
            end
        end
        bus_resp_valid = 1'b0;
        chk({tag, "_data"}, got, exp_data);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_bus_addr"}, req_a, {a[31:2], 2'b00});
`ifdef MC_MEM_MISALIGN_TRAP_EN
        chk({tag, "_mis"}, {31'h0, mis}, {31'h0, exp_mis});
`else
        chk({tag, "_mis_none"}, {31'h0, mis}, {31'h0, exp_mis});
`endif
    endtask

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mem_read_enable = 1'b0; mem_write_enable = 1'b0; inst_or_data = 1'b0;
        addr = 32'h0; wdata = 32'h0; funct3 = 3'b000;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 32'h0;
        #12;
        chk("rst_valid", {31'h0, bus_req_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_da", {31'h0, data_available}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr_be", {bus_req_addr[27:0], bus_req_be}, 32'h0);
        reset = 1'b0;
        cyc();

        do_read("fetch", 32'h104, 3'b000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_read("lb",    32'h203, 3'b000, 1'b1, 32'h80112233, 32'hFFFFFF80, 1'b0);
        do_read("lbu",   32'h203, 3'b100, 1'b1, 32'h80112233, 32'h00000080, 1'b0);
        do_read("lh",    32'h202, 3'b001, 1'b1, 32'h80112233, 32'hFFFF8011, 1'b0);
        do_read("lhu",   32'h202, 3'b101, 1'b1, 32'h80112233, 32'h00008011, 1'b0);
        do_read("lb0",   32'h200, 3'b000, 1'b1, 32'h80112233, 32'h00000033, 1'b0);
        do_read("lw",    32'h300, 3'b010, 1'b1, 32'h89ABCDEF, 32'h89ABCDEF, 1'b0);

        // SB: posted without stall, then drains as a lane-replicated write
        mem_write_enable = 1'b1; funct3 = 3'b000; addr = 32'h101; wdata = 32'h000000A5;
        bus_req_ready = 1'b1;
        #1;
        chk("sb_nostall", {31'h0, busy}, 32'h0);
        cyc();
        mem_write_enable = 1'b0;
        #1;
        chk("sb_req", {30'h0, bus_req_valid, bus_req_write}, 32'h3);
        chk("sb_addr", bus_req_addr, 32'h100);
        chk("sb_be", {28'h0, bus_req_be}, 32'h2);
        chk("sb_wdata", bus_req_wdata, 32'hA5A5A5A5);
        chk("sb_busy", {31'h0, busy}, 32'h1);
        cyc();
        #1;
        chk("sb_done", {30'h0, busy, bus_req_valid}, 32'h0);

        // Store and read in the same cycle with ready low: write must go first
        mem_write_enable = 1'b1; mem_read_enable = 1'b1; inst_or_data = 1'b1;
        funct3 = 3'b010; addr = 32'h40; wdata = 32'h11223344; bus_req_ready = 1'b0;
        #1;
        chk("ord_nostall", {31'h0, busy}, 32'h0);
        cyc();
        mem_write_enable = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ord_wr_hold", {30'h0, bus_req_valid, bus_req_write}, 32'h3);
            chk("ord_wr_addr", bus_req_addr, 32'h40);
            if (k < 2) begin
                cyc();
                #1;
            end
        end
        chk("ord_wr_data", bus_req_wdata, 32'h11223344);
        chk("ord_wr_be", {28'h0, bus_req_be}, 32'hF);
        bus_req_ready = 1'b1;
        cyc();
        #1;
        chk("ord_idle", {31'h0, bus_req_valid}, 32'h0);
        cyc();
        #1;
        chk("ord_rd_req", {30'h0, bus_req_valid, bus_req_write}, 32'h2);
        chk("ord_rd_addr", bus_req_addr, 32'h40);
        cyc();
        bus_resp_valid = 1'b1; bus_resp_data = 32'hCAFEF00D;
        cyc();
        bus_resp_valid = 1'b0;
        #1;
        chk("ord_rd_da", {31'h0, data_available}, 32'h1);
        chk("ord_rd_data", rdata, 32'hCAFEF00D);
        mem_read_enable = 1'b0;
        cyc();

        // Read abandoned after issue: response consumed, no data_available
        addr = 32'h600; funct3 = 3'b010; mem_read_enable = 1'b1; bus_req_ready = 1'b1;
        cyc();
        #1;
        chk("abort_req", {31'h0, bus_req_valid}, 32'h1);
        mem_read_enable = 1'b0;
        cyc();
        bus_resp_valid = 1'b1; bus_resp_data = 32'h12345678;
        cyc();
        bus_resp_valid = 1'b0;
        #1;
        chk("abort_da", {31'h0, data_available}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        cyc();
        #1;
        chk("abort_idle", {30'h0, bus_req_valid, data_available}, 32'h0);

        // Reset while waiting for a response
        addr = 32'h500; funct3 = 3'b010; mem_read_enable = 1'b1; bus_req_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rstw_busy_pre", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rstw_busy", {31'h0, busy}, 32'h0);
        chk("rstw_valid", {31'h0, bus_req_valid}, 32'h0);
        chk("rstw_rdata", rdata, 32'h0);
        mem_read_enable = 1'b0;
        #1;
        reset = 1'b0;
        cyc();
        do_read("post_rst", 32'h504, 3'b010, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b0);

`ifdef MC_MEM_MISALIGN_TRAP_EN
        do_read("lw_mis", 32'h102, 3'b010, 1'b1, 32'h55667788, 32'h0, 1'b1);
        mem_write_enable = 1'b1; funct3 = 3'b001; addr = 32'h1; wdata = 32'hBEEF;
        #1;
        chk("sh_mis_pulse", {31'h0, misaligned}, 32'h1);
        cyc();
        mem_write_enable = 1'b0;
        #1;
        chk("sh_mis_nowrite", {30'h0, bus_req_valid, busy}, 32'h0);
`else
        do_read("lh_mis", 32'h203, 3'b001, 1'b1, 32'h80112233, 32'hFFFF8011, 1'b0);
        mem_write_enable = 1'b1; funct3 = 3'b001; addr = 32'h3; wdata = 32'h0000BEEF;
        cyc();
        mem_write_enable = 1'b0;
        #1;
        chk("sh_mis_be", {28'h0, bus_req_be}, 32'hC);
        chk("sh_mis_data", bus_req_wdata, 32'hBEEFBEEF);
        chk("sh_mis_addr", bus_req_addr, 32'h0);
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_mem_port.md
Name: multicycle_mem_port

Overview:
Memory port adapter between the multicycle controller/datapath and a valid/ready memory bus. It sits directly upstream of the controller and produces the `data_available` handshake that the controller waits on in its fetch and memory-read states. It performs word-aligned bus reads with load formatting (byte/half extract, sign or zero extension). Stores are posted into a one-entry write buffer, so the single-cycle store state never stalls.

Parameters:
ADDR_WIDTH, 32, byte address width on the core and bus sides
BUS_ID, 0, constant returned on `bus_req_id` for multi-master tagging

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
mem_read_enable  in  1  core read request; held high until `data_available`
mem_write_enable  in  1  core store strobe; single cycle
inst_or_data  in  1  0 = instruction fetch (funct3 ignored, full word); 1 = data access (funct3 applies)
addr  in  ADDR_WIDTH  byte address
wdata  in  32  store data, right-aligned
funct3  in  3  load/store size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW encodings)
data_available  out  1  read data valid; one-cycle pulse
rdata  out  32  formatted read data; valid while `data_available` is high
busy  out  1  write buffer occupied or read in flight
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts request
bus_req_write  out  1  1 = write, 0 = read
bus_req_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2], 2'b00})
bus_req_wdata  out  32  lane-replicated store data
bus_req_be  out  4  byte enables
bus_req_id  out  4  equals BUS_ID
bus_resp_valid  in  1  read response valid; reads only, writes have no response
bus_resp_data  in  32  read response word

Behaviour:
- Reset values: all outputs 0; state IDLE; write buffer empty; rdata register 0.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.
- IDLE:
  - Write buffer full → WR_REQ. Pending stores always drain before any read (ordering).
  - Else if `mem_read_enable` → latch addr, funct3 and inst_or_data, then go to RD_REQ.
- WR_REQ:
  - Drive `bus_req_valid=1`, `bus_req_write=1` with the buffered address, data and byte enables.
  - On `bus_req_ready`: clear the buffer and return to IDLE.
- RD_REQ:
  - Drive `bus_req_valid=1`, `bus_req_write=0`, `bus_req_be=4'hF`.
  - On `bus_req_ready` → RD_WAIT.
  - `bus_req_*` stay stable while valid and not ready.
- RD_WAIT: on `bus_resp_valid`, register the formatted word into `rdata` → RD_DONE.
- RD_DONE:
  - `data_available=1` for exactly one cycle → IDLE.
  - Minimum read latency, request to `data_available`: 3 cycles (IDLE sample, accepted RD_REQ, response in RD_WAIT, then pulse).
- Store capture: `mem_write_enable` is sampled in any state.
  - The buffer stores the word address, byte enables and lane data.
  - SB: be = 4'b0001 << addr[1:0], byte replicated ×4.
  - SH: be = 4'b0011 << {addr[1],1'b0}, half replicated ×2.
  - SW: be = 4'hF.
- Load format:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Fetch (inst_or_data=0) returns the raw word.
- `mem_write_enable` while the buffer is full is a protocol violation. The entry is dropped and an immediate assertion fires. This cannot occur with the controller, because an intervening fetch drains the buffer.
- Simultaneous store capture and buffer drain (WR_REQ accepted in the same cycle): the new entry wins and the buffer stays full.
- `mem_read_enable` deasserted mid-read: the bus transaction completes and the response is consumed, but `data_available` is suppressed in RD_DONE.
- Reset mid-operation: immediate return to IDLE and the buffer is discarded. The bus is reset in the same domain, so no stale response arrives.
- Misalignment, feature off: low address bits are ignored for the bus address. A halfword at addr[1:0]=3 uses lane addr[1]=1.
- `busy` = buffer full OR state ∈ {RD_REQ, RD_WAIT}.

Optional Feature:
MC_MEM_MISALIGN_TRAP_EN
- Defined: adds output `misaligned` (1 bit, reset 0). It pulses with `data_available` for misaligned loads (LH/LHU with addr[0]=1, LW with addr[1:0]≠0). For misaligned stores it pulses in the capture cycle, and the store is not buffered. Misaligned load data is returned as 0.
- Undefined: no port; misaligned accesses are silently lane-truncated as described above.

Decomposition:
- Package `multicycle_mem_pkg`:
  - `mem_port_state_t` enum.
  - Funct3 size/sign localparams (reused from constants.sv values).
  - Write-buffer entry struct {addr, be, data}.
- One combinational sub-module `mem_lane_formatter`: store be/data generation and load extract/extend.

Test Plan:
- Fetch, addr 0x104, ready=1, resp 0xDEADBEEF one cycle later → `data_available` pulse with rdata 0xDEADBEEF, bus addr 0x104, latency 3.
- LB addr 0x203, resp 0x80112233 → rdata 0xFFFFFF80; LBU → 0x00000080; LH addr 0x202 → 0xFFFF8011.
- SB addr 0x101, wdata 0xA5 → bus write addr 0x100, be 4'b0010, wdata 0xA5A5A5A5; no stall on the capture cycle.
- Store at 0x40 followed by a same-cycle read request with bus_req_ready=0 for 3 cycles → write issued first, read request only after write acceptance.
- Reset asserted in RD_WAIT → outputs 0 asynchronously; next read proceeds normally with `data_available` exactly once.
- With MC_MEM_MISALIGN_TRAP_EN defined: LW addr 0x102 → `misaligned`=1 and rdata 0; SH addr 0x1 → `misaligned` pulse and no bus write.
